// File: rtl/alu_issue_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_issue_stage_if : decode-side and ALU-side handshake/data bundle   |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
interface alu_issue_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  aluop;
  logic [5:0]  funct;
  logic [4:0]  shamt_in;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [15:0] imm16;
  logic        alusrc;
  logic [4:0]  dest_in;
  logic        regwrite_in;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  gin;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  sham;
  logic [4:0]  dest;
  logic        regwrite;
  logic        illegal;
  logic [15:0] stall_cnt;

  modport master (
    output in_valid, aluop, funct, shamt_in, rs_data, rt_data, imm16,
           alusrc, dest_in, regwrite_in, flush, out_ready,
    input  in_ready, out_valid, gin, a, b, sham, dest, regwrite, illegal,
           stall_cnt
  );

  modport slave (
    input  in_valid, aluop, funct, shamt_in, rs_data, rt_data, imm16,
           alusrc, dest_in, regwrite_in, flush, out_ready,
    output in_ready, out_valid, gin, a, b, sham, dest, regwrite, illegal,
           stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_issue_stage : single-entry ID/EX register feeding the 32-bit ALU  |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module alu_issue_stage (
  input logic              clk,
  input logic              rst_n,
  alu_issue_stage_if.slave bus
);
  localparam logic [2:0]  GIN_AND   = 3'b000;
  localparam logic [2:0]  GIN_OR    = 3'b001;
  localparam logic [2:0]  GIN_ADD   = 3'b010;
  localparam logic [2:0]  GIN_XOR   = 3'b011;
  localparam logic [2:0]  GIN_SRL   = 3'b100;
  localparam logic [2:0]  GIN_SUB   = 3'b110;
  localparam logic [2:0]  GIN_SLT   = 3'b111;
  localparam logic [15:0] STALL_MAX = 16'hFFFF;

  logic        ready;
  logic        capture;
  logic        stalled;
  logic [2:0]  gin_d;
  logic        illegal_d;
  logic [31:0] b_d;
  logic [4:0]  sham_d;

  logic        valid_q;
  logic [2:0]  gin_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [4:0]  sham_q;
  logic [4:0]  dest_q;
  logic        regwrite_q;
  logic        illegal_q;
  logic [15:0] stall_q;

  assign ready   = !valid_q | bus.out_ready;
  assign capture = bus.in_valid & ready & !bus.flush;
  assign stalled = valid_q & !bus.out_ready & !bus.flush;

  always_comb begin
    gin_d     = GIN_ADD;
    illegal_d = 1'b0;
    case (bus.aluop)
      2'b00: gin_d = GIN_ADD;
      2'b01: gin_d = GIN_SUB;
      2'b11: gin_d = GIN_OR;
      default: begin
        case (bus.funct)
          6'b100000: gin_d = GIN_ADD;
          6'b100010: gin_d = GIN_SUB;
          6'b100100: gin_d = GIN_AND;
          6'b100101: gin_d = GIN_OR;
          6'b100110: gin_d = GIN_XOR;
          6'b101010: gin_d = GIN_SLT;
          6'b000010: gin_d = GIN_SRL;
          default:   illegal_d = 1'b1;
        endcase
      end
    endcase
  end

  // ori zero-extends its immediate; every other immediate form sign-extends
  always_comb begin
    b_d = bus.rt_data;
    if (bus.alusrc) begin
      if (bus.aluop == 2'b11) b_d = {16'h0000, bus.imm16};
      else                    b_d = {{16{bus.imm16[15]}}, bus.imm16};
    end
  end

  assign sham_d = (gin_d == GIN_SRL) ? bus.shamt_in : 5'd0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      gin_q      <= GIN_ADD;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      sham_q     <= 5'd0;
      dest_q     <= 5'd0;
      regwrite_q <= 1'b0;
      illegal_q  <= 1'b0;
      stall_q    <= 16'd0;
    end else begin
      if (bus.flush)         valid_q <= 1'b0;
      else if (capture)      valid_q <= 1'b1;
      else if (bus.out_ready) valid_q <= 1'b0;

      // data fields only move on a capture so a stalled bundle stays bit-stable
      if (capture) begin
        gin_q      <= gin_d;
        a_q        <= bus.rs_data;
        b_q        <= b_d;
        sham_q     <= sham_d;
        dest_q     <= bus.dest_in;
        regwrite_q <= bus.regwrite_in & !illegal_d;
        illegal_q  <= illegal_d;
      end

      if (stalled && (stall_q != STALL_MAX)) stall_q <= stall_q + 16'd1;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = valid_q;
  assign bus.gin       = gin_q;
  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.sham      = sham_q;
  assign bus.dest      = dest_q;
  assign bus.regwrite  = regwrite_q;
  assign bus.illegal   = illegal_q;
  assign bus.stall_cnt = stall_q;
endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_issue_stage : randomized scoreboard bench for alu_issue_stage  |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_alu_issue_stage;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_issue_stage_if bus();
  alu_issue_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [2:0]  gin;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sham;
    logic [4:0]  dest;
    logic        regwrite;
    logic        illegal;
  } bundle_t;

  int      total = 0;
  int      bad   = 0;
  bit      armed = 1'b0;
  bit      mdl_valid = 1'b0;
  int      mdl_stall = 0;
  bundle_t exp_q[$];
  logic [5:0] legal_fn [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                               6'b100110, 6'b101010, 6'b000010};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bundle_t reference(input logic [1:0] op, input logic [5:0] fn,
                                        input logic [4:0] sh, input logic [31:0] rs,
                                        input logic [31:0] rt, input logic [15:0] im,
                                        input logic src, input logic [4:0] d,
                                        input logic rw);
    bundle_t r;
    logic    ill;
    ill = 1'b0;
    case (op)
      2'd0: r.gin = 3'd2;
      2'd1: r.gin = 3'd6;
      2'd3: r.gin = 3'd1;
      default:
        if      (fn == 6'd32) r.gin = 3'd2;
        else if (fn == 6'd34) r.gin = 3'd6;
        else if (fn == 6'd36) r.gin = 3'd0;
        else if (fn == 6'd37) r.gin = 3'd1;
        else if (fn == 6'd38) r.gin = 3'd3;
        else if (fn == 6'd42) r.gin = 3'd7;
        else if (fn == 6'd2)  r.gin = 3'd4;
        else begin r.gin = 3'd2; ill = 1'b1; end
    endcase
    if (!src)           r.b = rt;
    else if (op == 2'd3) r.b = 32'(im);
    else                r.b = 32'($signed(im));
    r.a        = rs;
    r.sham     = (r.gin == 3'd4) ? sh : 5'd0;
    r.dest     = d;
    r.regwrite = rw && !ill;
    r.illegal  = ill;
    return r;
  endfunction

  // Input side of the model: records accepted instructions and stage occupancy.
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      mdl_valid = 1'b0;
      mdl_stall = 0;
    end else begin
      bit cap;
      cap = bus.in_valid && (!mdl_valid || bus.out_ready) && !bus.flush;
      if (mdl_valid && !bus.out_ready && !bus.flush && mdl_stall < 65535) mdl_stall++;
      if (cap) exp_q.push_back(reference(bus.aluop, bus.funct, bus.shamt_in, bus.rs_data,
                                         bus.rt_data, bus.imm16, bus.alusrc, bus.dest_in,
                                         bus.regwrite_in));
      if (bus.flush)          mdl_valid = 1'b0;
      else if (cap)           mdl_valid = 1'b1;
      else if (bus.out_ready) mdl_valid = 1'b0;
    end
  end

  // Output monitor: compares whatever the stage presents, retires on consume/flush.
  always @(negedge clk) begin
    if (armed && rst_n) begin
      chk("in_ready", 32'(bus.in_ready), 32'(!mdl_valid || bus.out_ready));
      chk("out_valid", 32'(bus.out_valid), 32'(mdl_valid));
      chk("stall_cnt", 32'(bus.stall_cnt), 32'(mdl_stall));
      if (mdl_valid) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
          bundle_t h;
          h = exp_q[0];
          chk("gin", 32'(bus.gin), 32'(h.gin));
          chk("a", bus.a, h.a);
          chk("b", bus.b, h.b);
          chk("sham", 32'(bus.sham), 32'(h.sham));
          chk("dest", 32'(bus.dest), 32'(h.dest));
          chk("regwrite", 32'(bus.regwrite), 32'(h.regwrite));
          chk("illegal", 32'(bus.illegal), 32'(h.illegal));
          if (bus.flush || bus.out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                     input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] im,
                     input logic src);
    bus.in_valid    = 1'b1;
    bus.aluop       = op;
    bus.funct       = fn;
    bus.shamt_in    = sh;
    bus.rs_data     = rs;
    bus.rt_data     = rt;
    bus.imm16       = im;
    bus.alusrc      = src;
    bus.dest_in     = 5'($urandom_range(31));
    bus.regwrite_in = 1'($urandom_range(1));
  endtask

  task automatic put_random();
    logic [5:0] fn;
    fn = ($urandom_range(3) == 0) ? 6'($urandom()) : legal_fn[$urandom_range(6)];
    put(2'($urandom_range(3)), fn, 5'($urandom()), $urandom(), $urandom(),
        16'($urandom()), 1'($urandom_range(1)));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_gin"}, 32'(bus.gin), 32'd2);
    chk({tag, "_a"}, bus.a, 32'd0);
    chk({tag, "_b"}, bus.b, 32'd0);
    chk({tag, "_sham"}, 32'(bus.sham), 32'd0);
    chk({tag, "_dest"}, 32'(bus.dest), 32'd0);
    chk({tag, "_regwrite"}, 32'(bus.regwrite), 32'd0);
    chk({tag, "_illegal"}, 32'(bus.illegal), 32'd0);
    chk({tag, "_stall_cnt"}, 32'(bus.stall_cnt), 32'd0);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    put_random();
    repeat (2) step();
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_reset("reset");
    armed = 1'b1;
    step();

    // R-type sweep plus one unsupported funct, full throughput
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      put(2'b10, legal_fn[i], 5'd3, 32'h0000_00F0, 32'h0000_000F, 16'h0000, 1'b0);
      step();
    end
    put(2'b10, 6'b111111, 5'd3, 32'h0000_00F0, 32'h0000_000F, 16'h0000, 1'b0);
    bus.regwrite_in = 1'b1;
    step();

    put(2'b00, 6'd0, 5'd0, 32'h1234_5678, 32'hDEAD_BEEF, 16'h8004, 1'b1);
    step();
    put(2'b11, 6'd0, 5'd0, 32'h1234_5678, 32'hDEAD_BEEF, 16'h8004, 1'b1);
    step();
    bus.in_valid = 1'b0;
    step();

    // backpressure: five stalled cycles while decode keeps presenting
    put_random();
    step();
    bus.out_ready = 1'b0;
    put_random();
    repeat (5) step();
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (2) step();

    // flush against an accept-ready stage drops the incoming instruction
    put_random();
    step();
    put_random();
    bus.flush = 1'b1;
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_drop", 32'(bus.out_valid), 32'd0);
    step();

    for (int i = 0; i < 400; i++) begin
      put_random();
      bus.in_valid  = ($urandom_range(9) < 7);
      bus.out_ready = ($urandom_range(9) < 6);
      bus.flush     = ($urandom_range(99) < 8);
      step();
    end
    bus.flush = 1'b0;

    // saturation of the stall counter
    bus.out_ready = 1'b1;
    put_random();
    step();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 65540; i++) begin
      bus.in_valid = 1'($urandom_range(1));
      step();
    end
    @(negedge clk);
    chk("stall_saturated", 32'(bus.stall_cnt), 32'h0000_FFFF);
    step();

    // reset in the middle of a stalled handshake
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    step();
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_reset("midreset");
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
